muldiv_sequencer: RTL and testbench

Iterative signed multiply/divide unit with its own sequencing FSM. It serves MULT and DIV for the multicycle control unit. The control unit pulses `start` with an opcode and the two register operands, then waits on `busy`/`done`. Results land in HI/LO, and divide-by-zero is flagged to the exception path. The block replaces the separate mult/div start controls and HI/LO load strobes with a single handshake.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_step.sv | 51 +++++
 rtl/muldiv_sequencer.sv | 162 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared types and constants for the iterative mult/div unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int   MULDIV_WIDTH = 32;
    localparam int   MULDIV_CNT_W = $clog2(MULDIV_WIDTH);

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MUL_RUN = 3'd1,
        ST_DIV_RUN = 3'd2,
        ST_DONE    = 3'd3,
        ST_ZERO    = 3'd4
    } state_t;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One radix-2 Booth step and one restoring-division step.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic [2*WIDTH:0]   i_prod,
    input  logic [WIDTH-1:0]   i_m,
    output logic [2*WIDTH:0]   o_booth,
    output logic [2*WIDTH:0]   o_div
);

    // Booth: accumulator is sign-extended one bit so that subtracting the
    // most negative multiplicand cannot overflow before the shift.
    logic [WIDTH:0] w_acc;
    logic [WIDTH:0] w_m_ext;
    logic [WIDTH:0] w_sum;

    assign w_acc   = {i_prod[2*WIDTH], i_prod[2*WIDTH:WIDTH+1]};
    assign w_m_ext = {i_m[WIDTH-1], i_m};

    always_comb begin
        w_sum = w_acc;
        case (i_prod[1:0])
            2'b01:   w_sum = w_acc + w_m_ext;
            2'b10:   w_sum = w_acc - w_m_ext;
            default: w_sum = w_acc;
        endcase
    end

    assign o_booth = {w_sum, i_prod[WIDTH:1]};

    // Restoring division: remainder in the upper half, dividend/quotient below.
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_rem;

    assign w_shift = {i_prod[2*WIDTH-1:WIDTH], i_prod[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, i_m});
    assign w_sub   = w_shift[WIDTH-1:0] - i_m;
    assign w_rem   = w_ge ? w_sub : w_shift[WIDTH-1:0];
    assign o_div   = {1'b0, w_rem, i_prod[WIDTH-2:0], w_ge};

endmodule : muldiv_step
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Iterative signed MULT/DIV with sequencing FSM and HI/LO regs.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             hilo_we,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH:0]   r_prod;
    logic [WIDTH-1:0]   r_m;
    logic               r_a_neg;
    logic               r_q_neg;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [2*WIDTH:0]   w_booth;
    logic [2*WIDTH:0]   w_div;
    logic               w_last;
    logic               w_b_zero;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    muldiv_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .i_prod  (r_prod),
        .i_m     (r_m),
        .o_booth (w_booth),
        .o_div   (w_div)
    );

    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_b_zero = (b == '0);
    // The most negative value maps to 2^(WIDTH-1), still exact as unsigned.
    assign w_a_mag  = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign w_b_mag  = b[WIDTH-1] ? (~b + 1'b1) : b;
    assign w_quo    = w_div[WIDTH-1:0];
    assign w_rem    = w_div[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        hilo_we     = 1'b0;
        div0        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (op == OP_MULT) begin
                        w_state_nxt = ST_MUL_RUN;
                    end else if (w_b_zero) begin
                        w_state_nxt = ST_ZERO;
                    end else begin
                        w_state_nxt = ST_DIV_RUN;
                    end
                end
            end
            ST_MUL_RUN, ST_DIV_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                hilo_we     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_ZERO: begin
                div0        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_prod  <= '0;
            r_m     <= '0;
            r_a_neg <= 1'b0;
            r_q_neg <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (start && (op == OP_MULT)) begin
                        r_prod <= {{WIDTH{1'b0}}, b, 1'b0};
                        r_m    <= a;
                    end else if (start && !w_b_zero) begin
                        r_prod  <= {1'b0, {WIDTH{1'b0}}, w_a_mag};
                        r_m     <= w_b_mag;
                        r_a_neg <= a[WIDTH-1];
                        r_q_neg <= a[WIDTH-1] ^ b[WIDTH-1];
                    end
                end
                ST_MUL_RUN: begin
                    r_prod <= w_booth;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_hi <= w_booth[2*WIDTH:WIDTH+1];
                        r_lo <= w_booth[WIDTH:1];
                    end
                end
                ST_DIV_RUN: begin
                    r_prod <= w_div;
                    r_cnt  <= r_cnt + 1'b1;
                    // Quotient truncates toward zero; remainder follows the dividend.
                    if (w_last) begin
                        r_lo <= r_q_neg ? (~w_quo + 1'b1) : w_quo;
                        r_hi <= r_a_neg ? (~w_rem + 1'b1) : w_rem;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule : muldiv_sequencer
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Scoreboard bench for muldiv_sequencer (reference in longint).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         hilo_we;
    logic         div0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct packed {
        logic         is_div0;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t         sb[$];
    int           n_vec  = 0;
    int           n_miss = 0;
    logic [W-1:0] m_hi   = '0;
    logic [W-1:0] m_lo   = '0;

    muldiv_sequencer #(
        .WIDTH   (W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .hilo_we (hilo_we),
        .div0    (div0),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   e;
        longint lx;
        longint ly;
        longint p;
        lx = longint'($signed(x));
        ly = longint'($signed(y));
        e.is_div0 = 1'b0;
        if (o == OP_MULT) begin
            p    = lx * ly;
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else if (y == '0) begin
            e.is_div0 = 1'b1;
        end else begin
            p    = lx / ly;
            m_lo = p[31:0];
            p    = lx % ly;
            m_hi = p[31:0];
        end
        e.hi = m_hi;
        e.lo = m_lo;
        sb.push_back(e);
    endtask

    task automatic run_op(input string tag, input logic o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input bit hold);
        int   k;
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        push_model(o, x, y);
        @(posedge clk);
        #1;
        start = hold;
        check({tag, "/busy_e0"}, 64'(busy), 64'd1);
        k = 0;
        while (!(done || div0) && k < 40) begin
            if (hold) begin
                op = ~op;
                a  = $urandom;
                b  = $urandom;
            end
            @(posedge clk);
            #1;
            k++;
        end
        start = 1'b0;
        e = sb.pop_front();
        check({tag, "/latency"}, 64'(k), e.is_div0 ? 64'd0 : 64'd32);
        check({tag, "/div0"},    64'(div0), 64'(e.is_div0));
        check({tag, "/done"},    64'(done), 64'(!e.is_div0));
        check({tag, "/hilo_we"}, 64'(hilo_we), 64'(!e.is_div0));
        check({tag, "/hilo"},    {hi, lo}, {e.hi, e.lo});
        @(posedge clk);
        #1;
        check({tag, "/busy_after"},  64'(busy), 64'd0);
        check({tag, "/pulse_after"}, {62'd0, done, div0}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset/flags", {60'd0, busy, done, hilo_we, div0}, 64'd0);
        check("reset/hilo",  {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("mul_7_m3", OP_MULT, 32'd7, -32'sd3, 1'b0);
        check("mul_7_m3/const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mul_min_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
        check("mul_min_min/const", {hi, lo}, 64'h4000_0000_0000_0000);
        run_op("div_m7_2", OP_DIV, -32'sd7, 32'd2, 1'b0);
        check("div_m7_2/const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_min_m1/const", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op("div_preload", OP_DIV, 32'h451, 32'h20, 1'b0);
        check("div_preload/const", {hi, lo}, 64'h0000_0011_0000_0022);
        run_op("div_by_zero", OP_DIV, 32'd5, 32'd0, 1'b0);
        check("div_by_zero/const", {hi, lo}, 64'h0000_0011_0000_0022);
        run_op("mul_hold_start", OP_MULT, 32'h1234, -32'sd85, 1'b1);
        n_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) n_done++;
        end
        check("mul_hold_start/extra_ops", 64'(n_done), 64'd0);

        // Abort a MULT after ten iterations.
        @(negedge clk);
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd99;
        b     = 32'd77;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort/flags", {60'd0, busy, done, hilo_we, div0}, 64'd0);
        check("abort/hilo",  {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        m_hi  = '0;
        m_lo  = '0;
        n_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) n_done++;
        end
        check("abort/no_done", 64'(n_done), 64'd0);
        run_op("mul_3_4", OP_MULT, 32'd3, 32'd4, 1'b0);
        check("mul_3_4/const", {hi, lo}, 64'd12);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), $urandom,
                   (i == 5) ? 32'd0 : $urandom, 1'b0);
        end

        check("scoreboard/empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_muldiv_sequencer
`default_nettype wire
